// File: rtl/ram_bus_arbiter.sv
// Shared RAM bus arbiter: the MEM-stage data port and the instruction-fetch
// port take turns on one single-port memory bus. Each access is a registered
// request held until a one-cycle ack or a bounded-wait timeout. Returned read
// data stays registered until the pipeline advances.
module ram_bus_arbiter #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_en,
  input  logic [31:0] inst_addr,
  output logic [31:0] inst_rdata,
  input  logic        ram_en,
  input  logic [3:0]  ram_write_en,
  input  logic [31:0] ram_addr,
  input  logic [31:0] ram_write_data,
  output logic [31:0] ram_rdata,
  output logic        bus_req,
  output logic [3:0]  bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  output logic        stall_req,
  output logic        bus_err
);

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    INST
  } state_e;

  // Last wait count before an unanswered request is abandoned.
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic        data_done_q, data_done_d;
  logic        inst_done_q, inst_done_d;
  logic [7:0]  wait_cnt_q, wait_cnt_d;
  logic        bus_req_q, bus_req_d;
  logic [3:0]  bus_we_q, bus_we_d;
  logic [31:0] bus_addr_q, bus_addr_d;
  logic [31:0] bus_wdata_q, bus_wdata_d;
  logic [31:0] inst_rdata_q, inst_rdata_d;
  logic [31:0] ram_rdata_q, ram_rdata_d;
  logic        bus_err_q, bus_err_d;

  logic        data_pend;
  logic        inst_pend;
  logic        timed_out;
  logic        finish;
  logic        issue_data;
  logic        issue_inst;

  // A port is pending while enabled and its access has not completed.
  assign data_pend = ram_en & ~data_done_q;
  assign inst_pend = inst_en & ~inst_done_q;
  assign stall_req = data_pend | inst_pend;

  assign timed_out = (wait_cnt_q == WAIT_LAST) & ~bus_ack;
  assign finish    = bus_ack | timed_out;

  // Next-state and registered-output logic for the access sequencer.
  always_comb begin
    state_d      = state_q;
    data_done_d  = data_done_q;
    inst_done_d  = inst_done_q;
    wait_cnt_d   = wait_cnt_q;
    bus_req_d    = bus_req_q;
    bus_we_d     = bus_we_q;
    bus_addr_d   = bus_addr_q;
    bus_wdata_d  = bus_wdata_q;
    inst_rdata_d = inst_rdata_q;
    ram_rdata_d  = ram_rdata_q;
    bus_err_d    = 1'b0;
    issue_data   = 1'b0;
    issue_inst   = 1'b0;

    case (state_q)
      IDLE: begin
        // Data wins: it belongs to the older instruction in the pipeline.
        if (data_pend) begin
          issue_data = 1'b1;
        end else if (inst_pend) begin
          issue_inst = 1'b1;
        end
      end

      DATA: begin
        if (finish) begin
          data_done_d = 1'b1;
          wait_cnt_d  = '0;
          bus_err_d   = timed_out;
          if (timed_out) begin
            ram_rdata_d = '0;
          end else if (bus_we_q == 4'h0) begin
            ram_rdata_d = bus_rdata;
          end
          // Chain straight into a pending fetch without an idle cycle.
          if (inst_pend) begin
            issue_inst = 1'b1;
          end else begin
            state_d   = IDLE;
            bus_req_d = 1'b0;
          end
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end

      INST: begin
        if (finish) begin
          inst_done_d  = 1'b1;
          wait_cnt_d   = '0;
          bus_err_d    = timed_out;
          inst_rdata_d = timed_out ? '0 : bus_rdata;
          state_d      = IDLE;
          bus_req_d    = 1'b0;
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end

      default: begin
        state_d   = IDLE;
        bus_req_d = 1'b0;
      end
    endcase

    if (issue_data) begin
      state_d     = DATA;
      bus_req_d   = 1'b1;
      bus_we_d    = ram_write_en;
      bus_addr_d  = ram_addr;
      bus_wdata_d = ram_write_data;
      wait_cnt_d  = '0;
    end else if (issue_inst) begin
      state_d     = INST;
      bus_req_d   = 1'b1;
      bus_we_d    = '0;
      bus_addr_d  = inst_addr;
      bus_wdata_d = '0;
      wait_cnt_d  = '0;
    end

    // Pipeline advanced: the next instruction starts with fresh flags.
    if (!stall_req) begin
      data_done_d = 1'b0;
      inst_done_d = 1'b0;
    end
  end

  // State and output registers; reset abandons any access in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      data_done_q  <= 1'b0;
      inst_done_q  <= 1'b0;
      wait_cnt_q   <= '0;
      bus_req_q    <= 1'b0;
      bus_we_q     <= '0;
      bus_addr_q   <= '0;
      bus_wdata_q  <= '0;
      inst_rdata_q <= '0;
      ram_rdata_q  <= '0;
      bus_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      data_done_q  <= data_done_d;
      inst_done_q  <= inst_done_d;
      wait_cnt_q   <= wait_cnt_d;
      bus_req_q    <= bus_req_d;
      bus_we_q     <= bus_we_d;
      bus_addr_q   <= bus_addr_d;
      bus_wdata_q  <= bus_wdata_d;
      inst_rdata_q <= inst_rdata_d;
      ram_rdata_q  <= ram_rdata_d;
      bus_err_q    <= bus_err_d;
    end
  end

  assign bus_req    = bus_req_q;
  assign bus_we     = bus_we_q;
  assign bus_addr   = bus_addr_q;
  assign bus_wdata  = bus_wdata_q;
  assign inst_rdata = inst_rdata_q;
  assign ram_rdata  = ram_rdata_q;
  assign bus_err    = bus_err_q;

endmodule
